mpu_matrix_streamer: RTL and testbench

MPU_MATRIX_STREAMER -- requirements
Module: mpu_matrix_streamer

---
 rtl/mpu_matrix_streamer.sv | 145 ++++++++++++++
 tb/tb_mpu_matrix_streamer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_matrix_streamer.sv
// mpu_matrix_streamer
// Accepts a DIM x DIM matrix in one parallel load and streams it out one
// element per beat over a valid/ready interface, in row-major or
// column-major order selected by the transpose bit sampled with the load.
// All stream outputs are registered, so out_valid never depends on out_ready.
// Index ports are 3 bits wide, which limits DIM to at most 8.

module mpu_matrix_streamer #(
    parameter int ELEM_W = 8,
    parameter int DIM    = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [ELEM_W*DIM*DIM-1:0]  matrix_flat,
    input  logic                       transpose,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ELEM_W-1:0]          out_data,
    output logic [2:0]                 out_row,
    output logic [2:0]                 out_col,
    output logic                       out_last,
    output logic                       busy
);

    localparam logic [2:0] LAST_IDX = 3'(DIM - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t            state;
    logic              mode;                  // 0 = row-major, 1 = column-major
    logic [2:0]        row;
    logic [2:0]        col;
    logic [ELEM_W-1:0] mem [DIM][DIM];

    logic [2:0]        nxt_row;
    logic [2:0]        nxt_col;
    logic              at_last;
    logic              nxt_last;

    // Handshake status is a pure decode of the state register.
    assign load_ready = (state == IDLE);
    assign busy       = (state == STREAM);

    // Position of the element that follows (row, col) in the selected order.
    always_comb begin
        nxt_row = row;
        nxt_col = col;
        if (!mode) begin
            if (col == LAST_IDX) begin
                nxt_col = 3'd0;
                nxt_row = row + 3'd1;
            end else begin
                nxt_col = col + 3'd1;
            end
        end else begin
            if (row == LAST_IDX) begin
                nxt_row = 3'd0;
                nxt_col = col + 3'd1;
            end else begin
                nxt_row = row + 3'd1;
            end
        end
        at_last  = (row == LAST_IDX) && (col == LAST_IDX);
        nxt_last = (nxt_row == LAST_IDX) && (nxt_col == LAST_IDX);
    end

    // Control FSM, matrix buffer and registered stream outputs.
    // NOTE: every register here uses <= so all reads in this block see the
    // pre-edge values; mixing in = would make results depend on statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mode      <= 1'b0;
            row       <= 3'd0;
            col       <= 3'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= 3'd0;
            out_col   <= 3'd0;
            out_last  <= 1'b0;
            // NOTE: the buffer is small and flop-based, so it is cleared on
            // reset; a RAM-style buffer would normally be left unreset.
            for (int i = 0; i < DIM; i++) begin
                for (int j = 0; j < DIM; j++) begin
                    mem[i][j] <= '0;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        for (int i = 0; i < DIM; i++) begin
                            for (int j = 0; j < DIM; j++) begin
                                mem[i][j] <= matrix_flat[ELEM_W*(DIM*i+j) +: ELEM_W];
                            end
                        end
                        mode      <= transpose;
                        row       <= 3'd0;
                        col       <= 3'd0;
                        state     <= STREAM;
                        out_valid <= 1'b1;
                        // First beat comes straight from the load bus so it
                        // is visible one cycle after the load edge.
                        out_data  <= matrix_flat[ELEM_W-1:0];
                        out_row   <= 3'd0;
                        out_col   <= 3'd0;
                        out_last  <= (DIM == 1);
                    end
                end

                STREAM: begin
                    if (out_ready) begin
                        if (at_last) begin
                            state     <= IDLE;
                            row       <= 3'd0;
                            col       <= 3'd0;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            out_row   <= 3'd0;
                            out_col   <= 3'd0;
                            out_last  <= 1'b0;
                        end else begin
                            row       <= nxt_row;
                            col       <= nxt_col;
                            out_data  <= mem[nxt_row][nxt_col];
                            out_row   <= nxt_row;
                            out_col   <= nxt_col;
                            out_last  <= nxt_last;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mpu_matrix_streamer.sv
// tb_mpu_matrix_streamer
// Directed scenarios plus randomized traffic. A queue-based model expands
// every accepted matrix into its list of expected beats; a compare process
// checks all outputs against the head of that list on every falling edge.

module tb_mpu_matrix_streamer;

    localparam int ELEM_W = 8;
    localparam int DIM    = 5;
    localparam int NBEAT  = DIM * DIM;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      load_valid;
    logic                      load_ready;
    logic [ELEM_W*DIM*DIM-1:0] matrix_flat;
    logic                      transpose;
    logic                      out_valid;
    logic                      out_ready;
    logic [ELEM_W-1:0]         out_data;
    logic [2:0]                out_row;
    logic [2:0]                out_col;
    logic                      out_last;
    logic                      busy;

    mpu_matrix_streamer #(.ELEM_W(ELEM_W), .DIM(DIM)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .matrix_flat (matrix_flat),
        .transpose   (transpose),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_row     (out_row),
        .out_col     (out_col),
        .out_last    (out_last),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ELEM_W-1:0] data;
        int                row;
        int                col;
        bit                last;
    } beat_t;

    beat_t mq[$];      // beats still owed for the matrix being streamed
    beat_t log_q[$];   // beats actually transferred by the DUT
    int    accepts = 0;
    int    tests   = 0;
    int    fails   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: an idle block accepts a load and owes NBEAT beats in the chosen
    // order; each ready cycle while beats are owed retires one of them.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
        end else if (mq.size() == 0) begin
            if (load_valid) begin
                for (int k = 0; k < NBEAT; k++) begin
                    beat_t b;
                    b.row  = transpose ? (k % DIM) : (k / DIM);
                    b.col  = transpose ? (k / DIM) : (k % DIM);
                    b.data = matrix_flat[ELEM_W*(DIM*b.row+b.col) +: ELEM_W];
                    b.last = (k == NBEAT - 1);
                    mq.push_back(b);
                end
                accepts++;
            end
        end else if (out_ready) begin
            void'(mq.pop_front());
        end
    end

    // Compare every cycle, away from the rising edge.
    always @(negedge clk) begin
        if (mq.size() > 0) begin
            check("out_valid", 32'(out_valid), 32'd1);
            check("out_data", 32'(out_data), 32'(mq[0].data));
            check("out_row", 32'(out_row), 32'(mq[0].row));
            check("out_col", 32'(out_col), 32'(mq[0].col));
            check("out_last", 32'(out_last), 32'(mq[0].last));
            check("load_ready", 32'(load_ready), 32'd0);
            check("busy", 32'(busy), 32'd1);
        end else begin
            check("out_valid_idle", 32'(out_valid), 32'd0);
            check("out_data_idle", 32'(out_data), 32'd0);
            check("out_row_idle", 32'(out_row), 32'd0);
            check("out_col_idle", 32'(out_col), 32'd0);
            check("out_last_idle", 32'(out_last), 32'd0);
            check("load_ready_idle", 32'(load_ready), 32'd1);
            check("busy_idle", 32'(busy), 32'd0);
        end
        if (!rst && out_valid && out_ready) begin
            beat_t b;
            b.data = out_data;
            b.row  = int'(out_row);
            b.col  = int'(out_col);
            b.last = out_last;
            log_q.push_back(b);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // kind 0: (i,j)=10*i+j, 1: all ones, 2: random, 3: 100+DIM*i+j
    task automatic set_matrix(input int kind);
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                logic [ELEM_W-1:0] v;
                case (kind)
                    0:       v = ELEM_W'(10 * i + j);
                    1:       v = '1;
                    2:       v = ELEM_W'($urandom);
                    default: v = ELEM_W'(100 + DIM * i + j);
                endcase
                matrix_flat[ELEM_W*(DIM*i+j) +: ELEM_W] = v;
            end
        end
    endtask

    task automatic load(input int kind, input logic tr);
        set_matrix(kind);
        transpose  = tr;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        transpose  = 1'b0;
        set_matrix(2);   // garbage on the bus must not matter after the load
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (mq.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(mq.size()), 32'd0);
    endtask

    int last_cnt;
    int n;
    int acc0;

    initial begin
        rst         = 1'b1;
        load_valid  = 1'b0;
        transpose   = 1'b0;
        out_ready   = 1'b1;
        matrix_flat = '0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_load_ready", 32'(load_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Row-major with continuous ready.
        log_q.delete();
        load(0, 1'b0);
        drain(40);
        check("rm_load_ready_after", 32'(load_ready), 32'd1);
        check("rm_beats", 32'(log_q.size()), 32'd25);
        check("rm_b0", 32'(log_q[0].data), 32'd0);
        check("rm_b4", 32'(log_q[4].data), 32'd4);
        check("rm_b5", 32'(log_q[5].data), 32'd10);
        check("rm_b24", 32'(log_q[24].data), 32'd44);
        check("rm_b24_row", 32'(log_q[24].row), 32'd4);
        check("rm_b24_col", 32'(log_q[24].col), 32'd4);
        check("rm_b24_last", 32'(log_q[24].last), 32'd1);
        last_cnt = 0;
        foreach (log_q[k]) if (log_q[k].last) last_cnt++;
        check("rm_last_count", 32'(last_cnt), 32'd1);
        tick();

        // Column-major.
        log_q.delete();
        load(0, 1'b1);
        drain(40);
        check("cm_beats", 32'(log_q.size()), 32'd25);
        check("cm_b1", 32'(log_q[1].data), 32'd10);
        check("cm_b4", 32'(log_q[4].data), 32'd40);
        check("cm_b5", 32'(log_q[5].data), 32'd1);
        check("cm_b24", 32'(log_q[24].data), 32'd44);
        last_cnt = 0;
        foreach (log_q[k]) if (log_q[k].last) last_cnt++;
        check("cm_last_count", 32'(last_cnt), 32'd1);
        tick();

        // Backpressure with ready pattern 1,0,0 repeating.
        log_q.delete();
        load(0, 1'b0);
        n = 0;
        while (mq.size() != 0 && n < 200) begin
            out_ready = (n % 3 == 0);
            tick();
            n++;
        end
        out_ready = 1'b1;
        check("bp_timeout", 32'(mq.size()), 32'd0);
        check("bp_beats", 32'(log_q.size()), 32'd25);
        for (int k = 0; k < NBEAT; k++)
            check("bp_seq", 32'(log_q[k].data), 32'(10 * (k / DIM) + k % DIM));
        tick();

        // Load held during a stream: second matrix waits for the last beat.
        log_q.delete();
        acc0 = accepts;
        set_matrix(0);
        load_valid = 1'b1;
        tick();
        set_matrix(3);
        n = 0;
        while (accepts == acc0 + 1 && n < 60) begin
            tick();
            n++;
        end
        load_valid = 1'b0;
        check("blk_period", 32'(n), 32'(NBEAT + 1));
        drain(40);
        check("blk_beats", 32'(log_q.size()), 32'd50);
        check("blk_a_last", 32'(log_q[24].data), 32'd44);
        check("blk_b_first", 32'(log_q[25].data), 32'd100);
        check("blk_b_last", 32'(log_q[49].data), 32'd124);
        tick();

        // Reset in the middle of a stream.
        load(2, 1'b0);
        repeat (7) tick();
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        check("post_rst_load_ready", 32'(load_ready), 32'd1);
        log_q.delete();
        load(0, 1'b0);
        drain(40);
        check("post_rst_beats", 32'(log_q.size()), 32'd25);
        check("post_rst_row0", 32'(log_q[0].row), 32'd0);
        check("post_rst_col0", 32'(log_q[0].col), 32'd0);
        tick();

        // All-ones matrix.
        log_q.delete();
        load(1, 1'b0);
        drain(40);
        check("ff_beats", 32'(log_q.size()), 32'd25);
        for (int k = 0; k < NBEAT; k++) begin
            check("ff_data", 32'(log_q[k].data), 32'hFF);
            check("ff_row", 32'(log_q[k].row), 32'(k / DIM));
            check("ff_col", 32'(log_q[k].col), 32'(k % DIM));
        end
        check("ff_data_after", 32'(out_data), 32'd0);
        tick();

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            load_valid = 1'($urandom_range(0, 1));
            transpose  = 1'($urandom_range(0, 1));
            out_ready  = ($urandom_range(0, 9) < 7);
            set_matrix(2);
            tick();
        end
        load_valid = 1'b0;
        out_ready  = 1'b1;
        drain(40);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
